// File: rtl/sram_arbiter.sv
// Purpose: two-port round-robin arbiter onto one single-port SRAM, with a port-ID FIFO routing each response back to its issuer.
// Latency: grant in the request cycle when the SRAM is ready and the FIFO has room; responses pass through with zero added cycles.
// Backpressure: a full routing FIFO forces mem_req_o/gnt_o low until a response pops an entry (slot usable the next cycle).
// Build option: define SRAM_ARB_FIXED_PRIO_EN to pin priority on port 0 instead of round-robin.
module sram_arbiter #(
    parameter int Aw          = 12,
    parameter int Dw          = 32,
    parameter int Outstanding = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          req_i,
    output logic [1:0]          gnt_o,
    input  logic [1:0]          we_i,
    input  logic [1:0][Aw-1:0]  addr_i,
    input  logic [1:0][Dw-1:0]  wdata_i,
    input  logic [1:0][Dw-1:0]  wmask_i,
    output logic [Dw-1:0]       rdata_o,
    output logic [1:0]          rvalid_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic                mem_we_o,
    output logic [Aw-1:0]       mem_addr_o,
    output logic [Dw-1:0]       mem_wdata_o,
    output logic [Dw-1:0]       mem_wmask_o,
    input  logic [Dw-1:0]       mem_rdata_i,
    input  logic                mem_rvalid_i
);

    localparam int CntW = $clog2(Outstanding + 1);
    localparam int PtrW = (Outstanding > 1) ? $clog2(Outstanding) : 1;

    // Selected request fields, bundled so the mux stays one expression.
    typedef struct packed {
        logic          we;
        logic [Aw-1:0] addr;
        logic [Dw-1:0] wdata;
        logic [Dw-1:0] wmask;
    } mem_cmd_t;

    logic                   prio_q;
    logic [Outstanding-1:0] id_q;
    logic [PtrW-1:0]        rd_ptr_q;
    logic [PtrW-1:0]        wr_ptr_q;
    logic [CntW-1:0]        count_q;

    logic     fifo_full;
    logic     fifo_empty;
    logic     sel;
    logic     mux_sel;
    logic     accept;
    logic     pop;
    mem_cmd_t cmd;

    assign fifo_full  = (count_q == CntW'(Outstanding));
    assign fifo_empty = (count_q == '0);

    // Preferred port wins if it asks, otherwise the other port; idle defaults to port 0.
    always_comb begin
        sel = 1'b0;
        if (req_i[prio_q]) begin
            sel = prio_q;
        end else if (req_i[~prio_q]) begin
            sel = ~prio_q;
        end
    end

    // Full depends only on registered count, so responses never reach gnt_o combinationally.
    assign mem_req_o = (|req_i) & ~fifo_full & ~reset;
    assign accept    = mem_req_o & mem_gnt_i;
    assign gnt_o     = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

    // Idle cycles present port 0's fields so the bus is never X.
    assign mux_sel = mem_req_o & sel;

    // Steer the chosen port's command fields onto the SRAM bus.
    always_comb begin
        cmd.we    = we_i[mux_sel];
        cmd.addr  = addr_i[mux_sel];
        cmd.wdata = wdata_i[mux_sel];
        cmd.wmask = wmask_i[mux_sel];
    end

    assign mem_we_o    = cmd.we;
    assign mem_addr_o  = cmd.addr;
    assign mem_wdata_o = cmd.wdata;
    assign mem_wmask_o = cmd.wmask;

    // A response with nothing outstanding is dropped rather than underflowing the FIFO.
    assign pop      = mem_rvalid_i & ~fifo_empty & ~reset;
    assign rvalid_o = pop ? (id_q[rd_ptr_q] ? 2'b10 : 2'b01) : 2'b00;
    assign rdata_o  = mem_rdata_i;

    // Round-robin pointer: after an accept the loser of that cycle becomes preferred.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            prio_q <= 1'b0;
`else
            if (accept) begin
                prio_q <= ~sel;
            end
`endif
        end
    end

    // Routing FIFO: pointers wrap at Outstanding so any depth works.
    always_ff @(posedge clock) begin
        if (reset) begin
            id_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                id_q[wr_ptr_q] <= sel;
                wr_ptr_q       <= (wr_ptr_q == PtrW'(Outstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrW'(Outstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Purpose: directed and randomized bench for sram_arbiter against a queue-based reference model.
// Latency: checks combinational outputs 1ns after each falling edge; model state advances on rising edges.
// Backpressure: models the routing FIFO as a queue of port IDs bounded by OUT entries.
module tb_sram_arbiter;

    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int OUT = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic [1:0]          req;
    logic [1:0]          gnt;
    logic [1:0]          we;
    logic [1:0][AW-1:0]  addr;
    logic [1:0][DW-1:0]  wdata;
    logic [1:0][DW-1:0]  wmask;
    logic [DW-1:0]       rdata;
    logic [1:0]          rvalid;
    logic                mem_req;
    logic                mem_gnt;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_wdata;
    logic [DW-1:0]       mem_wmask;
    logic [DW-1:0]       mem_rdata;
    logic                mem_rvalid;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding port IDs in issue order, plus the preferred port.
    int   q[$];
    int   rr;
    logic exp_acc;
    logic exp_pop;
    int   exp_win;

    logic [1:0] contention_seq [4];

    sram_arbiter #(.Aw(AW), .Dw(DW), .Outstanding(OUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_i       (req),
        .gnt_o       (gnt),
        .we_i        (we),
        .addr_i      (addr),
        .wdata_i     (wdata),
        .wmask_i     (wmask),
        .rdata_o     (rdata),
        .rvalid_o    (rvalid),
        .mem_req_o   (mem_req),
        .mem_gnt_i   (mem_gnt),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_wmask_o (mem_wmask),
        .mem_rdata_i (mem_rdata),
        .mem_rvalid_i(mem_rvalid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic check_cycle();
        logic       full;
        logic       mreq;
        logic [1:0] eg;
        logic [1:0] er;
        int         win;
        int         dwin;
        #1;
        full = (q.size() >= OUT);
        if (req[rr]) win = rr;
        else if (req[1-rr]) win = 1 - rr;
        else win = 0;
        mreq    = (req != 2'b00) && !full && !reset;
        exp_acc = mreq && mem_gnt;
        eg      = exp_acc ? 2'(1 << win) : 2'b00;
        exp_pop = mem_rvalid && (q.size() > 0) && !reset;
        er      = exp_pop ? 2'(1 << q[0]) : 2'b00;
        dwin    = mreq ? win : 0;
        exp_win = win;
        chk("mem_req",   32'(mem_req),   32'(mreq));
        chk("gnt",       32'(gnt),       32'(eg));
        chk("rvalid",    32'(rvalid),    32'(er));
        chk("rdata",     rdata,          mem_rdata);
        chk("mem_we",    32'(mem_we),    32'(we[dwin]));
        chk("mem_addr",  32'(mem_addr),  32'(addr[dwin]));
        chk("mem_wdata", mem_wdata,      wdata[dwin]);
        chk("mem_wmask", mem_wmask,      wmask[dwin]);
    endtask

    // Apply the clock edge to the model, then move to the next drive point.
    task automatic advance();
        @(posedge clock);
        if (reset) begin
            q.delete();
            rr = 0;
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_acc) begin
                q.push_back(exp_win);
`ifdef SRAM_ARB_FIXED_PRIO_EN
                rr = 0;
`else
                rr = 1 - exp_win;
`endif
            end
        end
        @(negedge clock);
    endtask

    task automatic idle();
        reset      = 1'b0;
        req        = 2'b00;
        we         = 2'b00;
        addr       = '0;
        wdata      = '0;
        wmask      = '0;
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        check_cycle();
        advance();
        reset = 1'b0;
    endtask

    initial begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        contention_seq = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        contention_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        rr = 0;
        idle();
        reset = 1'b1;
        req   = 2'b11;
        @(negedge clock);

        // Reset state: requests present but nothing granted or issued.
        check_cycle();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        advance();

        // Single-port read with one-cycle SRAM latency.
        idle();
        req = 2'b01; addr[0] = 12'h010;
        check_cycle();
        chk("single_gnt", 32'(gnt), 32'h1);
        chk("single_addr", 32'(mem_addr), 32'h010);
        advance();
        req = 2'b00; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        check_cycle();
        chk("single_rvalid", 32'(rvalid), 32'h1);
        chk("single_rdata", rdata, 32'hDEADBEEF);
        advance();

        // Contention with the SRAM always ready and answering every cycle.
        do_reset();
        req = 2'b11;
        for (int c = 0; c < 4; c++) begin
            mem_rvalid = (c > 0);
            check_cycle();
            chk("contention_gnt", 32'(gnt), 32'(contention_seq[c]));
            advance();
        end
        req = 2'b00; mem_rvalid = 1'b1;
        check_cycle();
        advance();

        // Backpressure: responses withheld, FIFO fills after two grants.
        do_reset();
        req = 2'b10;
        chk_bp: for (int c = 0; c < 4; c++) begin
            check_cycle();
            chk("bp_gnt", 32'(gnt), (c < 2) ? 32'h2 : 32'h0);
            advance();
        end
        // Pop on a full FIFO: no grant this cycle, grant on the next.
        mem_rvalid = 1'b1;
        check_cycle();
        chk("bp_pop_gnt", 32'(gnt), 32'h0);
        chk("bp_pop_rvalid", 32'(rvalid), 32'h2);
        advance();
        mem_rvalid = 1'b0;
        check_cycle();
        chk("bp_next_gnt", 32'(gnt), 32'h2);
        advance();
        req = 2'b00; mem_rvalid = 1'b1;
        check_cycle(); advance();
        check_cycle(); advance();

        // Ordering: read from port 0 then masked write from port 1, responses 3 cycles late.
        idle();
        req = 2'b01; addr[0] = 12'h004;
        check_cycle();
        chk("ord_gnt0", 32'(gnt), 32'h1);
        advance();
        req = 2'b10; we = 2'b10; addr[1] = 12'h008;
        wdata[1] = 32'h12345678; wmask[1] = 32'hFFFF0000;
        check_cycle();
        chk("ord_gnt1", 32'(gnt), 32'h2);
        chk("ord_wmask", mem_wmask, 32'hFFFF0000);
        chk("ord_we", 32'(mem_we), 32'h1);
        chk("ord_addr", 32'(mem_addr), 32'h008);
        advance();
        idle();
        check_cycle(); advance();
        mem_rvalid = 1'b1;
        check_cycle();
        chk("ord_rvalid_first", 32'(rvalid), 32'h1);
        advance();
        check_cycle();
        chk("ord_rvalid_second", 32'(rvalid), 32'h2);
        advance();

        // Reset with two requests in flight; late responses must be discarded.
        do_reset();
        req = 2'b01;
        check_cycle(); advance();
        check_cycle(); advance();
        req = 2'b00; reset = 1'b1;
        check_cycle();
        chk("midrst_gnt", 32'(gnt), 32'h0);
        advance();
        reset = 1'b0; mem_rvalid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            check_cycle();
            chk("midrst_rvalid", 32'(rvalid), 32'h0);
            advance();
        end
        mem_rvalid = 1'b0; req = 2'b11;
        check_cycle();
        chk("midrst_gnt_after", 32'(gnt), 32'h1);
        advance();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 59) == 0);
            req        = 2'($urandom);
            we         = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                addr[k]  = AW'($urandom);
                wdata[k] = $urandom;
                wmask[k] = $urandom;
            end
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            check_cycle();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
